// File: rtl/tdm_demux8_if.sv
// Bundle of the serial slot stream, the parallel frame output and the status pulses of the
// 8-slot TDM demultiplexer.
interface tdm_demux8_if #(
  parameter int unsigned W = 8
);
  logic           in_valid;
  logic           in_sof;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [8*W-1:0] out_data;
  logic           frame_err;
  logic           overflow;
  logic [7:0]     frame_cnt;

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output out_valid, out_data, frame_err, overflow, frame_cnt
  );

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  out_valid, out_data, frame_err, overflow, frame_cnt
  );
endinterface

// File: rtl/tdm_demux8.sv
// 8-slot TDM demultiplexer: collects a serial frame of 8 beats (slot 0 marked by sof) into a
// shadow buffer and presents the complete frame as one 8*W word behind a valid/ready handshake.
module tdm_demux8 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux8_if.slave  bus
);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  state_e         st_q, st_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   shadow_q [7];
  logic           wr_en;
  logic [2:0]     wr_idx;
  logic           complete;
  logic           load;
  logic [8*W-1:0] frame;
  logic [8*W-1:0] out_data_q;
  logic           out_valid_q, out_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     frame_cnt_q;
  logic           handshake;

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;
    if (bus.in_valid) begin
      case (st_q)
        StHunt: begin
          if (bus.in_sof) begin
            wr_en  = 1'b1;
            wr_idx = 3'd0;
            cnt_d  = 3'd1;
            st_d   = StRecv;
          end
        end
        StRecv: begin
          if (bus.in_sof) begin
            // Restart on a premature sof; the stale slots get overwritten before use.
            frame_err_d = 1'b1;
            wr_en       = 1'b1;
            wr_idx      = 3'd0;
            cnt_d       = 3'd1;
          end else if (cnt_q == 3'd7) begin
            complete = 1'b1;
            cnt_d    = 3'd0;
            st_d     = StHunt;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          st_d  = StHunt;
          cnt_d = 3'd0;
        end
      endcase
    end
  end

  // The slot-7 beat goes straight into the output word, so it is never buffered.
  always_comb begin
    frame = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      frame[k*W +: W] = shadow_q[k];
    end
    frame[7*W +: W] = bus.in_data;
  end

  assign handshake   = out_valid_q & bus.out_ready;
  assign load        = complete & (~out_valid_q | bus.out_ready);
  assign overflow_d  = complete & out_valid_q & ~bus.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StHunt;
      cnt_q       <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      for (int unsigned k = 0; k < 7; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (load) begin
        out_data_q <= frame;
      end
      if (handshake) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      for (int unsigned k = 0; k < 7; k++) begin
        if (wr_en && wr_idx == 3'(k)) begin
          shadow_q[k] <= bus.in_data;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed frame scenarios followed by random traffic, all checked
// against a queue-based frame-assembly model.
module tb_tdm_demux8;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux8_if #(.W(W)) bus ();

  tdm_demux8 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the partial frame is a queue of received beats.
  logic [7:0]  part [$];
  bit          in_frame;
  logic [63:0] m_data;
  bit          m_valid;
  bit          m_err;
  bit          m_ovf;
  logic [7:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    in_frame = 1'b0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = 8'd0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [7:0] d, input bit r);
    bit          hs;
    bit          done;
    bit          err;
    logic [63:0] fr;
    hs   = m_valid && r;
    done = 1'b0;
    err  = 1'b0;
    fr   = '0;
    if (v) begin
      if (s) begin
        err = in_frame;
        part.delete();
        part.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        part.push_back(d);
        if (part.size() == 8) begin
          for (int i = 0; i < 8; i++) fr[i*8 +: 8] = part[i];
          done = 1'b1;
          part.delete();
          in_frame = 1'b0;
        end
      end
    end
    m_ovf = done && m_valid && !r;
    m_err = err;
    if (done && (!m_valid || r)) begin
      m_data  = fr;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (hs) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic compare_all();
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("out_data",  bus.out_data,       m_data);
    check("frame_err", 64'(bus.frame_err), 64'(m_err));
    check("overflow",  64'(bus.overflow),  64'(m_ovf));
    check("frame_cnt", 64'(bus.frame_cnt), 64'(m_cnt));
  endtask

  task automatic cycle(input bit v, input bit s, input logic [7:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    model_step(v, s, d, r);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] base, input bit r);
    for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, base + 8'(i), r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_data"},  bus.out_data,       64'd0);
    check({tag, "_err"},   64'(bus.frame_err), 64'd0);
    check({tag, "_ovf"},   64'(bus.overflow),  64'd0);
    check({tag, "_cnt"},   64'(bus.frame_cnt), 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    release_reset();

    // Basic back-to-back frame with ready held high.
    send_frame(8'h10, 1'b1);
    check("basic_data", bus.out_data, 64'h1716151413121110);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("basic_cnt", 64'(bus.frame_cnt), 64'd1);

    // Beats before any sof are discarded.
    cycle(1'b1, 1'b0, 8'hAA, 1'b1);
    cycle(1'b1, 1'b0, 8'hBB, 1'b1);
    send_frame(8'h00, 1'b1);
    check("hunt_data", bus.out_data, 64'h0706050403020100);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Premature sof restarts the frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, 8'h20 + 8'(i), 1'b1);
    cycle(1'b1, 1'b1, 8'h30, 1'b1);
    check("err_pulse", 64'(bus.frame_err), 64'd1);
    for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, 8'h30 + 8'(i), 1'b1);
    check("err_data", bus.out_data, 64'h3736353433323130);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Handshake and reload on the same edge.
    send_frame(8'h40, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, 8'h50 + 8'(i), i == 7);
    check("reload_valid", 64'(bus.out_valid), 64'd1);
    check("reload_data", bus.out_data, 64'h5756555453525150);
    check("reload_ovf", 64'(bus.overflow), 64'd0);

    // Reset between edges part way through a frame while a frame is held.
    for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 8'h60 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    release_reset();
    for (int i = 4; i < 8; i++) cycle(1'b1, 1'b0, 8'h60 + 8'(i), 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("midreset_novalid", 64'(bus.out_valid), 64'd0);

    // Output full: second frame is dropped with an overflow pulse.
    send_frame(8'hA0, 1'b0);
    send_frame(8'hB0, 1'b0);
    check("ovf_pulse", 64'(bus.overflow), 64'd1);
    check("ovf_hold", bus.out_data, 64'hA7A6A5A4A3A2A1A0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("ovf_cnt", 64'(bus.frame_cnt), 64'd1);

    // Random traffic with gaps, stray sofs and backpressure.
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 8) == 0,
            8'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width per channel slot.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  serial slot beat present this cycle.
REQ-006 in_sof  input  1  beat is slot 0 (start of frame); ignored when in_valid=0.
REQ-007 in_data  input  W  slot payload.
REQ-008 out_valid  output  1  a complete 8-channel frame is held on out_data.
REQ-009 out_ready  input  1  consumer accepts the frame when out_valid=1.
REQ-010 out_data  output  8*W  frame; channel k occupies bits [k*W +: W], channel 0 = SOF beat.
REQ-011 frame_err  output  1  one-cycle pulse: in_sof arrived before slot 7 of the current frame.
REQ-012 overflow  output  1  one-cycle pulse: completed frame dropped because the output was still full.
REQ-013 frame_cnt  output  8  count of frames delivered (handshakes), wraps 255->0.

Function
REQ-014 The block SHALL demultiplex a time-division stream of 8 slots per frame into a parallel 8-channel register, the inverse of the team's 8:1 channel mux.
REQ-015 The FSM SHALL have two states: HUNT and RECV; a 3-bit slot counter and an 8xW shadow buffer.
REQ-016 HUNT: beats with in_sof=0 SHALL be discarded; in_valid&in_sof SHALL write in_data to shadow slot 0, set counter=1, go to RECV.
REQ-017 RECV: in_valid&!in_sof SHALL write in_data to shadow slot[counter] and increment counter.
REQ-018 RECV: a beat written to slot 7 SHALL complete the frame, return FSM to HUNT, and counter to 0.
REQ-019 RECV: in_valid&in_sof SHALL pulse frame_err next cycle, discard the partial frame, write in_data to slot 0, set counter=1, stay RECV.
REQ-020 Cycles with in_valid=0 SHALL leave state, counter and shadow unchanged (gaps allowed anywhere).
REQ-021 On completion, if out_valid=0 or out_ready=1 this cycle, out_data SHALL load shadow slots 0-6 plus the slot-7 beat in the same edge, and out_valid SHALL be 1 the following cycle (latency 1 cycle from last beat).
REQ-022 On completion with out_valid=1 and out_ready=0, the new frame SHALL be dropped, out_data/out_valid unchanged, overflow pulsed next cycle.
REQ-023 out_valid SHALL clear after an edge with out_valid&out_ready unless a completion loads in that same edge (then it stays 1 with new data).
REQ-024 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 frame_cnt SHALL increment by 1 on every out_valid&out_ready edge, modulo 256.
REQ-026 frame_err and overflow SHALL be registered, high for exactly one cycle per event, and may both pulse in one cycle.
REQ-027 No output SHALL depend combinationally on any input.

Reset
REQ-028 rst_n=0 SHALL immediately force FSM=HUNT, counter=0, shadow=0, out_data=0, out_valid=0, frame_err=0, overflow=0, frame_cnt=0, independent of clk.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL ignore beats until the next in_sof.
REQ-030 out_valid SHALL remain 0 for at least the first 8 valid beats after reset release.

Verification
REQ-031 W=8, out_ready=1, beats 0x10(sof),0x11..0x17 back-to-back -> one cycle after the 0x17 beat out_valid=1, out_data=0x1716151413121110, frame_cnt=1 after that handshake.
REQ-032 Beats 0xAA,0xBB (no sof) then a full frame 0x00(sof)..0x07 -> 0xAA/0xBB discarded, out_data=0x0706050403020100.
REQ-033 Sof frame 0x20..0x24, then sof 0x30..0x37 -> frame_err pulses once after the 0x30 beat, out_data=0x3736353433323130.
REQ-034 out_ready=0, two complete frames A then B -> out_data holds A, overflow pulses once after B's last beat; then out_ready=1 -> one handshake, frame_cnt=1.
REQ-035 out_valid=1 with out_ready=1 in the same cycle as next frame's slot-7 beat -> out_valid stays 1, out_data updates to new frame, no overflow.
REQ-036 Assert rst_n=0 between edges after 4 beats of a frame -> all outputs 0 immediately; after release, remaining 4 beats without sof produce no out_valid.
